// File: rtl/circle_sprite_layer.sv
// rtl/circle_sprite_layer.sv - bouncing filled/ring circle sprites over a 96x64 OLED pixel stream
module circle_sprite_layer #(
  parameter int          N_CIRC = 2,
  parameter int          ID_W   = 1,
  parameter int          SCR_W  = 96,
  parameter int          SCR_H  = 64,
  parameter int          RING_W = 2,
  parameter int          SPEED  = 1,
  parameter logic [15:0] BG     = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [12:0]           pixel_index,
  input  logic                  frame_tick,
  input  logic [5:0]            radius,
  input  logic                  ring_mode,
  input  logic                  move_en,
  input  logic [N_CIRC-1:0]     enable,
  input  logic [16*N_CIRC-1:0]  colours,
  input  logic                  load,
  input  logic [ID_W-1:0]       load_id,
  input  logic [6:0]            load_x,
  input  logic [6:0]            load_y,
  output logic [15:0]           oled_data,
  output logic [7*N_CIRC-1:0]   pos_x,
  output logic [7*N_CIRC-1:0]   pos_y
);

  logic [6:0]        cx [N_CIRC];
  logic [6:0]        cy [N_CIRC];
  logic [N_CIRC-1:0] dir_x;  // 1 = moving towards larger coordinates
  logic [N_CIRC-1:0] dir_y;
  logic [7:0]        nx [N_CIRC];
  logic [7:0]        ny [N_CIRC];

  logic [6:0]        px, py;
  logic              in_range_s1;
  logic [6:0]        dx_s1 [N_CIRC];
  logic [6:0]        dy_s1 [N_CIRC];
  logic [15:0]       next_data;

  // Returns {flip, new_centre}; 9-bit arithmetic keeps c+SPEED+r from wrapping.
  function automatic logic [7:0] step_axis(input logic [6:0] c, input logic up,
                                           input logic [5:0] r, input logic [8:0] size);
    logic [8:0] cw, rw, spd, lim;
    cw  = {2'b00, c};
    rw  = {3'b000, r};
    spd = 9'(SPEED);
    lim = size - 9'd1;
    if ((rw << 1) + 9'd1 > size)
      step_axis = {1'b0, c};
    else if (up)
      step_axis = (cw + spd + rw > lim) ? {1'b1, 7'(lim - rw)} : {1'b0, 7'(cw + spd)};
    else
      step_axis = (cw < rw + spd) ? {1'b1, 7'(rw)} : {1'b0, 7'(cw - spd)};
  endfunction

  function automatic logic [6:0] abs_diff(input logic [6:0] a, input logic [6:0] b);
    abs_diff = (a >= b) ? a - b : b - a;
  endfunction

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < N_CIRC; i++) begin
      nx[i] = step_axis(cx[i], dir_x[i], radius, 9'(SCR_W));
      ny[i] = step_axis(cy[i], dir_y[i], radius, 9'(SCR_H));
      pos_x[7*i +: 7] = cx[i];
      pos_y[7*i +: 7] = cy[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CIRC; i++) begin
        cx[i] <= 7'(SCR_W / 2);
        cy[i] <= 7'(SCR_H / 2);
      end
      dir_x <= '1;
      dir_y <= '1;
    end else begin
      for (int i = 0; i < N_CIRC; i++) begin
        if (load && load_id == ID_W'(i)) begin
          cx[i] <= load_x;
          cy[i] <= load_y;
        end else if (frame_tick && move_en) begin
          cx[i] <= nx[i][6:0];
          cy[i] <= ny[i][6:0];
          if (nx[i][7]) dir_x[i] <= ~dir_x[i];
          if (ny[i][7]) dir_y[i] <= ~dir_y[i];
        end
      end
    end
  end

  assign px = 7'(pixel_index % 13'(SCR_W));
  assign py = 7'(pixel_index / 13'(SCR_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_range_s1 <= 1'b0;
      for (int i = 0; i < N_CIRC; i++) begin
        dx_s1[i] <= '0;
        dy_s1[i] <= '0;
      end
    end else begin
      in_range_s1 <= pixel_index < 13'(SCR_W * SCR_H);
      for (int i = 0; i < N_CIRC; i++) begin
        dx_s1[i] <= abs_diff(px, cx[i]);
        dy_s1[i] <= abs_diff(py, cy[i]);
      end
    end
  end

  // A ring thinner than its own width degenerates to a filled disc.
  always_comb begin
    logic [11:0] rw, iw, rr, ri;
    logic [14:0] dxw, dyw, d2;
    logic        ring_eff, found;
    rw       = 12'(radius);
    iw       = 12'(radius - 6'(RING_W));
    rr       = rw * rw;
    ri       = iw * iw;
    ring_eff = ring_mode && (radius > 6'(RING_W));
    found    = 1'b0;
    next_data = BG;
    for (int i = 0; i < N_CIRC; i++) begin
      dxw = 15'(dx_s1[i]);
      dyw = 15'(dy_s1[i]);
      d2  = dxw * dxw + dyw * dyw;
      if (!found && enable[i] && d2 <= 15'(rr) && (!ring_eff || d2 > 15'(ri))) begin
        found     = 1'b1;
        next_data = colours[16*i +: 16];
      end
    end
    if (!in_range_s1) next_data = BG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oled_data <= BG;
    else        oled_data <= next_data;
  end

endmodule

// File: tb/tb_circle_sprite_layer.sv
// tb/tb_circle_sprite_layer.sv - randomized bench for circle_sprite_layer against a behavioural model
module tb_circle_sprite_layer;
  logic        clk, rst_n;
  logic [12:0] pixel_index;
  logic        frame_tick, ring_mode, move_en, load;
  logic [5:0]  radius;
  logic [1:0]  enable;
  logic [31:0] colours;
  logic [0:0]  load_id;
  logic [6:0]  load_x, load_y;
  logic [15:0] oled_data;
  logic [13:0] pos_x, pos_y;

  int vectors = 0;
  int miscompares = 0;
  int mcx [2], mcy [2], mdx [2], mdy [2];
  int idx_q [$];

  circle_sprite_layer dut (
    .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index), .frame_tick(frame_tick),
    .radius(radius), .ring_mode(ring_mode), .move_en(move_en), .enable(enable),
    .colours(colours), .load(load), .load_id(load_id), .load_x(load_x),
    .load_y(load_y), .oled_data(oled_data), .pos_x(pos_x), .pos_y(pos_y)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcx[i] = 48; mcy[i] = 32; mdx[i] = 1; mdy[i] = 1;
    end
  endtask

  task automatic model_axis(input int c, input int d, input int r, input int size,
                            output int nc, output int nd);
    nc = c; nd = d;
    if (2 * r + 1 > size) return;
    if (d > 0) begin
      if (c + 1 + r > size - 1) begin nc = size - 1 - r; nd = -1; end
      else nc = c + 1;
    end else begin
      if (c < r + 1) begin nc = r; nd = 1; end
      else nc = c - 1;
    end
  endtask

  function automatic logic [15:0] pix_model(input int idx);
    int x, y, d2, r;
    x = idx % 96;
    y = idx / 96;
    r = radius;
    if (idx >= 96 * 64) return 16'h0000;
    for (int i = 0; i < 2; i++) begin
      d2 = (x - mcx[i]) * (x - mcx[i]) + (y - mcy[i]) * (y - mcy[i]);
      if (enable[i] && d2 <= r * r && !(ring_mode && r > 2 && d2 <= (r - 2) * (r - 2)))
        return colours[16*i +: 16];
    end
    return 16'h0000;
  endfunction

  task automatic check_pos();
    for (int i = 0; i < 2; i++) begin
      check_val("pos_x", 32'(pos_x[7*i +: 7]), 32'(mcx[i]));
      check_val("pos_y", 32'(pos_y[7*i +: 7]), 32'(mcy[i]));
    end
  endtask

  // Entered and left on a falling edge; applies one control cycle then checks centres.
  task automatic ctl_cycle(input bit ft, input bit ld, input int id, input int lx, input int ly);
    int nc, nd;
    frame_tick = ft; load = ld; load_id = 1'(id); load_x = 7'(lx); load_y = 7'(ly);
    for (int i = 0; i < 2; i++) begin
      if (ld && id == i) begin
        mcx[i] = lx; mcy[i] = ly;
      end else if (ft && move_en) begin
        model_axis(mcx[i], mdx[i], radius, 96, nc, nd); mcx[i] = nc; mdx[i] = nd;
        model_axis(mcy[i], mdy[i], radius, 64, nc, nd); mcy[i] = nc; mdy[i] = nd;
      end
    end
    @(negedge clk);
    frame_tick = 0; load = 0;
    check_pos();
  endtask

  task automatic run_pixels(input string tag);
    logic [15:0] expq [$];
    foreach (idx_q[k]) begin
      pixel_index = 13'(idx_q[k]);
      expq.push_back(pix_model(idx_q[k]));
      @(negedge clk);
      if (expq.size() == 2) check_val(tag, 32'(oled_data), 32'(expq.pop_front()));
    end
    @(negedge clk);
    if (expq.size() > 0) check_val(tag, 32'(oled_data), 32'(expq.pop_front()));
    idx_q.delete();
  endtask

  initial begin
    rst_n = 1; pixel_index = 0; frame_tick = 0; ring_mode = 0; move_en = 0; load = 0;
    radius = 6; enable = 2'b01; colours = {16'h07E0, 16'hF800};
    load_id = 0; load_x = 0; load_y = 0;
    model_reset();
    #3 rst_n = 0;
    #1;
    check_val("rst_oled", 32'(oled_data), 32'h0);
    check_val("rst_pos_x", 32'(pos_x), {18'd0, 7'd48, 7'd48});
    check_val("rst_pos_y", 32'(pos_y), {18'd0, 7'd32, 7'd32});
    @(negedge clk);
    rst_n = 1;

    idx_q = '{3120, 3127, 3126};
    run_pixels("filled");
    check_val("filled_spot", 32'(pix_model(3126)), 32'hF800);

    ring_mode = 1;
    idx_q = '{3120, 3126, 6144};
    run_pixels("ring");
    ring_mode = 0;

    enable = 2'b11;
    idx_q = '{3120};
    run_pixels("prio11");
    enable = 2'b10;
    idx_q = '{3120};
    run_pixels("prio10");
    enable = 2'b01;

    ctl_cycle(0, 1, 0, 88, 32);
    move_en = 1;
    foreach (idx_q[k]) ;
    begin
      int xs [4] = '{89, 89, 88, 87};
      int ys [3] = '{6, 6, 7};
      for (int k = 0; k < 4; k++) begin
        ctl_cycle(1, 0, 0, 0, 0);
        check_val("bounce_hi", 32'(pos_x[6:0]), 32'(xs[k]));
      end
      ctl_cycle(0, 1, 0, 7, 32);
      for (int k = 0; k < 3; k++) begin
        ctl_cycle(1, 0, 0, 0, 0);
        check_val("bounce_lo", 32'(pos_x[6:0]), 32'(ys[k]));
      end
    end

    ctl_cycle(1, 1, 1, 20, 20);
    check_val("ld_tick_c0", 32'(pos_x[6:0]), 32'd8);
    check_val("ld_tick_c1", {18'd0, pos_y[13:7], pos_x[13:7]}, {18'd0, 7'd20, 7'd20});

    for (int round = 0; round < 8; round++) begin
      radius    = 6'($urandom_range(0, 40));
      ring_mode = 1'($urandom_range(0, 1));
      enable    = 2'($urandom_range(0, 3));
      colours   = $urandom;
      move_en   = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++)
        ctl_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 127));
      for (int k = 0; k < 40; k++)
        idx_q.push_back($urandom_range(0, 66) * 96 + $urandom_range(0, 95));
      run_pixels("rand_pix");
    end

    radius = 6; ring_mode = 0; enable = 2'b01; colours = {16'h07E0, 16'hF800}; move_en = 0;
    ctl_cycle(0, 1, 0, 48, 32);
    pixel_index = 13'd3120;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst", 32'(oled_data), 32'hF800);
    #1 rst_n = 0;
    #1;
    model_reset();
    check_val("mid_rst_oled", 32'(oled_data), 32'h0);
    check_pos();
    @(negedge clk);
    rst_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
